fir_sample_feeder: RTL and testbench



---
 rtl/fir_sample_feeder.sv | 107 ++++++++++
 tb/tb_fir_sample_feeder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: FIFO-buffered, rate-paced sample source for the fir block.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_sample upstream
// handshake; ena/sample strobe and data toward fir; level = FIFO occupancy;
// underflow = sticky empty-slot flag, cleared by clr_underflow.
module fir_sample_feeder #(
   parameter int W     = 16,
   parameter int DEPTH = 4,
   parameter int RATE  = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [W-1:0]               in_sample,
   output logic                       ena,
   output logic [W-1:0]               sample,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       underflow,
   input  logic                       clr_underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = (RATE > 1) ? $clog2(RATE) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [CW-1:0] rcnt;
   logic          tick;
   logic          push;
   logic          pop;
   logic          dry;

   // Slot timing runs free, independent of data presence.
   assign tick = (rcnt == CW'(RATE - 1));

   // Readiness uses only registered occupancy: a full FIFO never
   // accepts a word even when the same edge pops one.
   assign in_ready = (level < LW'(DEPTH)) && !rst;
   assign push     = in_valid && in_ready;

   // Registered level excludes a word written on this same edge,
   // so there is no push-to-pop bypass.
   assign pop = tick && (level != '0);
   assign dry = tick && (level == '0);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= in_sample;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rcnt <= '0;
      end else if (tick) begin
         rcnt <= '0;
      end else begin
         rcnt <= rcnt + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + AW'(1);
         end
         if (pop) begin
            rptr <= rptr + AW'(1);
         end
         if (push && !pop) begin
            level <= level + LW'(1);
         end else if (pop && !push) begin
            level <= level - LW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ena    <= 1'b0;
         sample <= '0;
      end else begin
         ena <= pop;
         if (pop) begin
            sample <= mem[rptr];
         end
      end
   end

   // Set has priority over a coincident clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         underflow <= 1'b0;
      end else if (dry) begin
         underflow <= 1'b1;
      end else if (clr_underflow) begin
         underflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb_fir_sample_feeder: directed bench for fir_sample_feeder (W=16, DEPTH=4,
// RATE=2): cycle table plus back-pressure and mid-stream reset sequences.
module tb_fir_sample_feeder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_sample;
   logic        ena;
   logic [15:0] sample;
   logic [2:0]  level;
   logic        underflow;
   logic        clr_underflow;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] q[$];

   fir_sample_feeder #(
      .W(16),
      .DEPTH(4),
      .RATE(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_sample(in_sample),
      .ena(ena),
      .sample(sample),
      .level(level),
      .underflow(underflow),
      .clr_underflow(clr_underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r;
      logic        vl;
      logic        cl;
      logic [15:0] d;
      logic        rd;
      logic        en;
      logic [15:0] s;
      logic [2:0]  l;
      logic        u;
   } vec_t;

   vec_t tbl[28];

   function automatic vec_t mk(logic r, logic vl, logic cl, logic [15:0] d,
                               logic rd, logic en, logic [15:0] s,
                               logic [2:0] l, logic u);
      vec_t t;
      t.r = r; t.vl = vl; t.cl = cl; t.d = d;
      t.rd = rd; t.en = en; t.s = s; t.l = l; t.u = u;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // One clock with scoreboard: accepted words queue up, each ena pops one.
   task automatic cyc(input logic v, input logic [15:0] d,
                      output bit a, output bit e);
      in_valid  = v;
      in_sample = d;
      #1;
      a = v && in_ready;
      if (a) q.push_back(d);
      @(posedge clk);
      #1;
      e = ena;
      if (ena) begin
         if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_extra: ena with nothing expected, sample %h", sample);
         end else begin
            chk("sb_sample", {16'h0, sample}, {16'h0, q.pop_front()});
         end
      end
   endtask

   initial begin
      bit a;
      bit e;
      bit full;
      int acc;
      int pulses;
      int nin;
      int nout;
      int since;
      bit seen;
      logic [15:0] nxt;

      tbl[0]  = mk(1,1,0,16'h5555, 0,0,16'h0000,3'd0,0);
      tbl[1]  = mk(1,1,0,16'h5555, 0,0,16'h0000,3'd0,0);
      tbl[2]  = mk(1,1,0,16'h5555, 0,0,16'h0000,3'd0,0);
      tbl[3]  = mk(0,1,0,16'h0001, 1,0,16'h0000,3'd1,0);
      tbl[4]  = mk(0,1,0,16'h0002, 1,1,16'h0001,3'd1,0);
      tbl[5]  = mk(0,1,0,16'h0003, 1,0,16'h0001,3'd2,0);
      tbl[6]  = mk(0,1,0,16'h0004, 1,1,16'h0002,3'd2,0);
      tbl[7]  = mk(0,0,0,16'h0000, 1,0,16'h0002,3'd2,0);
      tbl[8]  = mk(0,0,0,16'h0000, 1,1,16'h0003,3'd1,0);
      tbl[9]  = mk(0,0,0,16'h0000, 1,0,16'h0003,3'd1,0);
      tbl[10] = mk(0,0,0,16'h0000, 1,1,16'h0004,3'd0,0);
      tbl[11] = mk(0,0,0,16'h0000, 1,0,16'h0004,3'd0,0);
      tbl[12] = mk(0,0,0,16'h0000, 1,0,16'h0004,3'd0,1);
      tbl[13] = mk(0,0,1,16'h0000, 1,0,16'h0004,3'd0,0);
      tbl[14] = mk(0,1,0,16'h1234, 1,0,16'h0004,3'd1,1);
      tbl[15] = mk(0,0,1,16'h0000, 1,0,16'h0004,3'd1,0);
      tbl[16] = mk(0,0,0,16'h0000, 1,1,16'h1234,3'd0,0);
      tbl[17] = mk(0,0,0,16'h0000, 1,0,16'h1234,3'd0,0);
      tbl[18] = mk(0,0,1,16'h0000, 1,0,16'h1234,3'd0,1);
      tbl[19] = mk(0,0,1,16'h0000, 1,0,16'h1234,3'd0,0);
      tbl[20] = mk(0,1,0,16'h8000, 1,0,16'h1234,3'd1,1);
      tbl[21] = mk(0,1,1,16'h7FFF, 1,0,16'h1234,3'd2,0);
      tbl[22] = mk(0,1,0,16'hFFFF, 1,1,16'h8000,3'd2,0);
      tbl[23] = mk(0,0,0,16'h0000, 1,0,16'h8000,3'd2,0);
      tbl[24] = mk(0,0,0,16'h0000, 1,1,16'h7FFF,3'd1,0);
      tbl[25] = mk(0,0,0,16'h0000, 1,0,16'h7FFF,3'd1,0);
      tbl[26] = mk(0,0,0,16'h0000, 1,1,16'hFFFF,3'd0,0);
      tbl[27] = mk(0,0,0,16'h0000, 1,0,16'hFFFF,3'd0,0);

      rst = 1'b1;
      in_valid = 1'b0;
      in_sample = '0;
      clr_underflow = 1'b0;

      for (int i = 0; i < 28; i++) begin
         rst           = tbl[i].r;
         in_valid      = tbl[i].vl;
         clr_underflow = tbl[i].cl;
         in_sample     = tbl[i].d;
         #1;
         chk($sformatf("v%0d_ready", i), {31'h0, in_ready}, {31'h0, tbl[i].rd});
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_ena", i), {31'h0, ena}, {31'h0, tbl[i].en});
         chk($sformatf("v%0d_sample", i), {16'h0, sample}, {16'h0, tbl[i].s});
         chk($sformatf("v%0d_level", i), {29'h0, level}, {29'h0, tbl[i].l});
         chk($sformatf("v%0d_uf", i), {31'h0, underflow}, {31'h0, tbl[i].u});
      end

      // Back-pressure with in_valid held high.
      clr_underflow = 1'b0;
      rst = 1'b1;
      cyc(1'b0, 16'h0, a, e);
      q.delete();
      rst = 1'b0;
      nxt = 16'h0100;
      nin = 0;
      nout = 0;
      full = 1'b0;
      for (int c = 0; c < 40 && !full; c++) begin
         cyc(1'b1, nxt, a, e);
         if (a) begin nxt++; nin++; end
         if (e) nout++;
         if (level == 3'd4) full = 1'b1;
      end
      chk("bp_full", {31'h0, full}, 32'h1);
      #1;
      chk("bp_ready_low", {31'h0, in_ready}, 32'h0);
      acc = 0;
      pulses = 0;
      for (int c = 0; c < 20; c++) begin
         cyc(1'b1, nxt, a, e);
         if (a) begin nxt++; nin++; acc++; end
         if (e) begin nout++; pulses++; end
      end
      chk("bp_one_per_ena", acc, pulses);
      chk("bp_pulses", pulses, 10);
      for (int c = 0; c < 40 && level != 3'd0; c++) begin
         cyc(1'b0, 16'h0, a, e);
         if (e) nout++;
      end
      chk("bp_drained", {29'h0, level}, 32'h0);
      chk("bp_words", nout, nin);

      // Reset while three words are buffered.
      for (int c = 0; c < 20 && level != 3'd3; c++) begin
         cyc(1'b1, 16'h0B00 + 16'(c), a, e);
      end
      chk("mr_level3", {29'h0, level}, 32'h3);
      rst = 1'b1;
      cyc(1'b0, 16'h0, a, e);
      q.delete();
      chk("mr_level0", {29'h0, level}, 32'h0);
      chk("mr_sample0", {16'h0, sample}, 32'h0);
      chk("mr_ena0", {31'h0, ena}, 32'h0);
      rst = 1'b0;
      seen = 1'b0;
      since = 0;
      for (int c = 0; c < 12 && !seen; c++) begin
         cyc(c == 0, 16'h00AA, a, e);
         since++;
         if (c == 0) chk("mr_push", {31'h0, a}, 32'h1);
         if (e) begin
            seen = 1'b1;
            chk("mr_sample_aa", {16'h0, sample}, 32'h00AA);
            chk("mr_latency", {31'h0, (since >= 2)}, 32'h1);
         end
      end
      chk("mr_ena_seen", {31'h0, seen}, 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
